// File: rtl/adder_share_arb.sv
// adder_share_arb
// Round-robin arbiter and sequencer that time-shares one registered W-bit
// adder among NREQ requesters. A granted requester's operands are latched,
// summed in the following cycle, and the sum/carry/parity are returned with
// a one-cycle one-hot acknowledge. Every operation takes exactly 3 cycles
// (IDLE -> EXEC -> DONE).
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req       per-requester request level
//   a_bus     operand A, requester i on [i*W +: W]
//   b_bus     operand B, same packing
//   ack       one-hot, one-cycle result-valid pulse
//   result    (A+B) mod 2^W, held until the next completion
//   carry     carry-out of A+B, held with result
//   parity    XOR reduction of result, held with result
//   grant_id  index of the current/last granted requester
//   busy      high while the sequencer is not idle
module adder_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         a_bus,
  input  logic [NREQ*W-1:0]         b_bus,
  output logic [NREQ-1:0]           ack,
  output logic [W-1:0]              result,
  output logic                      carry,
  output logic                      parity,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gid_q, gid_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            parity_q, parity_d;
  logic            busy_q, busy_d;

  logic            found_s;
  logic [PW-1:0]   pick_s;
  logic [PW-1:0]   idx_s;
  logic [W:0]      sum_s;

  // Even-parity helper: XOR reduction of a result word.
  function automatic logic parity_f(input logic [W-1:0] v);
    return ^v;
  endfunction

  // Round-robin search starting at the pointer; PW-bit index arithmetic
  // wraps naturally because NREQ is a power of two.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = ptr_q + PW'(k);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Shared adder operates only on the latched operands.
  always_comb begin
    sum_s = {1'b0, op_a_q} + {1'b0, op_b_q};
  end

  // Sequencer next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    ack_d    = '0;
    result_d = result_q;
    carry_d  = carry_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          op_a_d  = a_bus[pick_s*W +: W];
          op_b_d  = b_bus[pick_s*W +: W];
          gid_d   = pick_s;
          ptr_d   = pick_s + PW'(1'b1);
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d = sum_s[W-1:0];
        carry_d  = sum_s[W];
        parity_d = parity_f(sum_s[W-1:0]);
        ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << gid_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // req is deliberately ignored here; IDLE re-arbitrates next cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gid_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      ack_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      parity_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gid_q    <= gid_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      parity_q <= parity_d;
      busy_q   <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign parity   = parity_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb (NREQ=4, W=4). Expected completions are
// queued when a request is driven; a negedge monitor pops and compares each
// acknowledge against the queue head.
module tb_adder_share_arb;

  localparam int NREQ = 4;
  localparam int W    = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] ackv;
    logic [3:0] res;
    logic       c;
    logic       p;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*W-1:0]     a_bus;
  logic [NREQ*W-1:0]     b_bus;
  logic [NREQ-1:0]       ack;
  logic [W-1:0]          result;
  logic                  carry;
  logic                  parity;
  logic [1:0]            grant_id;
  logic                  busy;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   order[5] = '{0, 1, 2, 3, 0};

  adder_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .a_bus    (a_bus),
    .b_bus    (b_bus),
    .ack      (ack),
    .result   (result),
    .carry    (carry),
    .parity   (parity),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [3:0] a, input logic [3:0] b);
    exp_t       r;
    logic [4:0] s;
    s      = {1'b0, a} + {1'b0, b};
    r.id   = 2'(id);
    r.ackv = 4'b0001 << id;
    r.res  = s[3:0];
    r.c    = s[4];
    r.p    = ^s[3:0];
    return r;
  endfunction

  task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b);
    a_bus[id*W +: W] = a;
    b_bus[id*W +: W] = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every acknowledge must match the oldest expectation.
  always @(negedge clk) begin
    if (ack !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack",      32'(ack),      32'(mon_e.ackv));
        check("ack_gid",  32'(grant_id), 32'(mon_e.id));
        check("result",   32'(result),   32'(mon_e.res));
        check("carry",    32'(carry),    32'(mon_e.c));
        check("parity",   32'(parity),   32'(mon_e.p));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    a_bus = 16'h0000;
    b_bus = 16'h0000;
    tick(2);
    // Reset values.
    check("rst_ack",    32'(ack),      32'd0);
    check("rst_result", 32'(result),   32'd0);
    check("rst_carry",  32'(carry),    32'd0);
    check("rst_parity", 32'(parity),   32'd0);
    check("rst_gid",    32'(grant_id), 32'd0);
    check("rst_busy",   32'(busy),     32'd0);
    rst_n = 1'b1;

    // Single request: 3+8.
    set_op(0, 4'd3, 4'd8);
    exp_q.push_back(mk(0, 4'd3, 4'd8));
    req = 4'b0001;
    tick(1);
    check("t1_gid",   32'(grant_id), 32'd0);
    check("t1_busy0", 32'(busy),     32'd1);
    check("t1_noack", 32'(ack),      32'd0);
    req = 4'b0000;
    tick(1);
    check("t1_busy1", 32'(busy),     32'd1);
    tick(1);
    check("t1_busy2", 32'(busy),     32'd0);
    check("t1_ackclr", 32'(ack),     32'd0);
    check("t1_res",   32'(result),   32'd11);
    check("t1_carry", 32'(carry),    32'd0);
    check("t1_par",   32'(parity),   32'd1);
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // Overflow on requester 2: 15+1.
    set_op(2, 4'd15, 4'd1);
    exp_q.push_back(mk(2, 4'd15, 4'd1));
    req = 4'b0100;
    tick(1);
    check("t2_gid", 32'(grant_id), 32'd2);
    req = 4'b0000;
    tick(2);
    check("t2_res",   32'(result), 32'd0);
    check("t2_carry", 32'(carry),  32'd1);
    check("t2_par",   32'(parity), 32'd0);
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // All four continuously requesting after reset: 0,1,2,3,0.
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    set_op(0, 4'd1,  4'd2);
    set_op(1, 4'd7,  4'd9);
    set_op(2, 4'd10, 4'd10);
    set_op(3, 4'd12, 4'd5);
    exp_q.push_back(mk(0, 4'd1,  4'd2));
    exp_q.push_back(mk(1, 4'd7,  4'd9));
    exp_q.push_back(mk(2, 4'd10, 4'd10));
    exp_q.push_back(mk(3, 4'd12, 4'd5));
    exp_q.push_back(mk(0, 4'd1,  4'd2));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      check("t3_gid",  32'(grant_id), 32'(order[g]));
      check("t3_busy", 32'(busy),     32'd1);
      tick(2);
    end
    req = 4'b0000;
    tick(1);
    check("t3_idle",  32'(busy), 32'd0);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // Round-robin skip: grant 1 first, then req=1001 gives 3 then 0.
    set_op(1, 4'd4, 4'd4);
    exp_q.push_back(mk(1, 4'd4, 4'd4));
    req = 4'b0010;
    tick(1);
    check("t4_gid1", 32'(grant_id), 32'd1);
    req = 4'b0000;
    tick(2);
    set_op(3, 4'd6,  4'd13);
    set_op(0, 4'd11, 4'd2);
    exp_q.push_back(mk(3, 4'd6,  4'd13));
    exp_q.push_back(mk(0, 4'd11, 4'd2));
    req = 4'b1001;
    tick(1);
    check("t4_gid3", 32'(grant_id), 32'd3);
    tick(2);
    req = 4'b0001;
    tick(1);
    check("t4_gid0", 32'(grant_id), 32'd0);
    req = 4'b0000;
    tick(2);
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // Withdrawal before the grant edge: no grant.
    req = 4'b0001;
    #3;
    req = 4'b0000;
    tick(1);
    check("t5_nobusy", 32'(busy),     32'd0);
    tick(1);
    check("t5_nobusy2", 32'(busy),    32'd0);
    check("t5_gid",    32'(grant_id), 32'd0);
    // Withdrawal during EXEC: still completes with latched operands.
    set_op(2, 4'd9, 4'd9);
    exp_q.push_back(mk(2, 4'd9, 4'd9));
    req = 4'b0100;
    tick(1);
    check("t5_gid2", 32'(grant_id), 32'd2);
    req = 4'b0000;
    set_op(2, 4'd0, 4'd0);
    tick(2);
    check("t5_drain", 32'(exp_q.size()), 32'd0);

    // Reset during EXEC: immediate clear, no ack; pending req granted after.
    set_op(3, 4'd5, 4'd6);
    req = 4'b1000;
    tick(1);
    check("t6_gid3", 32'(grant_id), 32'd3);
    check("t6_busy", 32'(busy),     32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_ack",    32'(ack),      32'd0);
    check("t6_result", 32'(result),   32'd0);
    check("t6_carry",  32'(carry),    32'd0);
    check("t6_parity", 32'(parity),   32'd0);
    check("t6_gid",    32'(grant_id), 32'd0);
    check("t6_busy0",  32'(busy),     32'd0);
    req = 4'b0010;
    set_op(1, 4'd7, 4'd12);
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(mk(1, 4'd7, 4'd12));
    tick(1);
    check("t6_gid1",  32'(grant_id), 32'd1);
    check("t6_busy1", 32'(busy),     32'd1);
    req = 4'b0000;
    tick(2);
    check("t6_res",   32'(result), 32'd3);
    check("t6_carry1", 32'(carry), 32'd1);
    check("t6_drain", 32'(exp_q.size()), 32'd0);
    tick(2);
    check("t6_quiet", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin arbiter and sequencer that time-shares one registered W-bit adder among NREQ requesters. Each requester presents two operands with a level request; the block grants one requester at a time, latches its operands, computes sum, carry-out and XOR parity, and returns them with a one-cycle acknowledge to the granted requester. It sits between several client blocks and a single shared add/parity datapath, replacing per-client adders.

## Interface
- NREQ, 4, number of requesters; power of two, 2..8
- W, 4, operand/result width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request level
- a_bus  input  NREQ*W  operand A; requester i on bits [i*W +: W]
- b_bus  input  NREQ*W  operand B; same packing
- ack  output  NREQ  one-hot, one-cycle pulse: result valid for that requester
- result  output  W  (A+B) mod 2^W, held until next completion
- carry  output  1  carry-out of A+B, held with result
- parity  output  1  XOR reduction of result, held with result
- grant_id  output  clog2(NREQ)  index of current/last granted requester
- busy  output  1  high when state != IDLE

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE, rr pointer=0, ack=0, result=0, carry=0, parity=0, grant_id=0, busy=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE: if req==0, stay. Otherwise choose the first requester with req high, searching upward from the rr pointer with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...). At the edge: latch that requester's A and B into operand registers, set grant_id, set rr pointer to (grant+1) mod NREQ, go to EXEC.
- EXEC: at the edge, register {carry,result} = A+B (W+1-bit unsigned add) and parity = ^result; set ack[grant_id]=1; go to DONE.
- DONE: ack high for exactly this cycle; at the edge clear ack and go to IDLE. req is not sampled in EXEC or DONE.
- Arithmetic: unsigned. Examples at W=4: 3+8 gives result=11, carry=0. 15+1 gives result=0, carry=1.
- Requester rules: hold req and operands stable until the grant edge. Deassert req in the cycle after ack is seen. A req still high when IDLE resamples is a new request, arbitrated round-robin against the others.
- Withdrawal: req dropped before the grant edge means no grant for that requester. Once granted, the operation completes and ack is issued regardless of req.
- Simultaneous requests: exactly one grant per pass. The rr pointer guarantees each continuously requesting client is served within NREQ passes.
- Reset mid-operation (EXEC or DONE): immediate return to reset values. No ack is issued for the aborted operation.

## Timing
- Latency: req sampled at IDLE edge E0 -> ack high in the cycle after E1 -> back in IDLE after E2. Fixed 3 cycles per operation.
- Back-to-back: with a different requester already pending, next grant at E3. Peak throughput is one operation per 3 cycles.
- result, carry and parity update only at the EXEC->DONE edge. They are stable from ack onward until the next completion.
- grant_id updates at the grant edge and holds through IDLE until the next grant.
- busy is high from after E0 through the DONE cycle.
- All outputs are registered. There is no combinational path from req, a_bus or b_bus to any output.

## Test plan
- Single request: req=0001, A0=3, B0=8 → ack=0001 for one cycle 2 edges after grant; result=11, carry=0, parity=1; busy high 2 cycles.
- Overflow: requester 2 with A=15, B=1 → result=0, carry=1, parity=0, ack=0100, grant_id=2.
- All four request continuously after reset: grants in order 0,1,2,3,0. Each ack one-hot, spaced 3 cycles apart. Results match each requester's own operands.
- Round-robin skip: last grant was 1; req=1001 → next grant is 3, then 0.
- Withdrawal: req0 raised then dropped before the IDLE edge → no grant, busy stays 0. Req dropped during EXEC → ack still issued with the correct sum.
- Reset asserted in EXEC → all outputs zero immediately, no ack. After release, a pending req=0010 is granted on the first IDLE edge.
